// File: rtl/mtm_alu_pkg.sv
// mtm_alu_pkg: shared constants and types for the ALU result serializer.
//   FRAME_BITS   bits per serial frame (start, type, 8 data, stop)
//   TYPE_DATA/CTL value of the type bit for C bytes / the CTL byte
//   DATA_FRAMES  frames in a data response (4 C bytes + CTL)
//   ser_state_e  serializer FSM states
//   frame_byte() picks the byte for a frame from the number of frames left
package mtm_alu_pkg;

    localparam int         FRAME_BITS  = 11;
    localparam logic       TYPE_DATA   = 1'b0;
    localparam logic       TYPE_CTL    = 1'b1;
    localparam logic [2:0] DATA_FRAMES = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_TYPE  = 3'd2,
        ST_DATA  = 3'd3,
        ST_STOP  = 3'd4,
        ST_GAP   = 3'd5
    } ser_state_e;

    // Frames are counted down, so 5 left means C[31:24] and 1 left means CTL.
    function automatic logic [7:0] frame_byte(input logic [31:0] c,
                                              input logic [7:0]  ctl,
                                              input logic [2:0]  frames_left);
        logic [7:0] b;
        case (frames_left)
            3'd5:    b = c[31:24];
            3'd4:    b = c[23:16];
            3'd3:    b = c[15:8];
            3'd2:    b = c[7:0];
            default: b = ctl;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/mtm_alu_serializer_if.sv
// mtm_alu_serializer_if: result handshake plus serial line of the serializer.
//   in_valid/in_ready  transfer handshake (transfer = in_valid & in_ready)
//   C, CTL_in          result captured on a transfer
//   sout, busy         serial line (idle high) and packet-in-flight flag
// master: upstream / observer side; slave: the serializer.
interface mtm_alu_serializer_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] C;
    logic [7:0]  CTL_in;
    logic        sout;
    logic        busy;

    modport master (output in_valid, C, CTL_in, input in_ready, sout, busy);
    modport slave  (input in_valid, C, CTL_in, output in_ready, sout, busy);
endinterface

// File: rtl/mtm_alu_frame_tx.sv
// mtm_alu_frame_tx: shifts one 11-bit frame {0, type, byte[7:0], 1} out MSB first.
//   clk, rst     clock, asynchronous active-high reset
//   start        load a new frame; the start bit appears on sout next cycle
//   tx_type      type bit of the frame
//   tx_byte      payload byte
//   sout         registered serial output, high when idle
//   tick         last cycle of the current bit (bit boundary)
//   done         last cycle of the stop bit; a start here chains frames gap-free
// Parameter BIT_CYCLES: clk cycles per bit (>=1).
module mtm_alu_frame_tx
    import mtm_alu_pkg::*;
#(
    parameter int BIT_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       tx_type,
    input  logic [7:0] tx_byte,
    output logic       sout,
    output logic       tick,
    output logic       done
);

    localparam int              DIV_W    = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(BIT_CYCLES - 1);

    logic [FRAME_BITS-1:0] shift_q, shift_d;
    logic [3:0]            bit_cnt_q, bit_cnt_d;
    logic [DIV_W-1:0]      div_q, div_d;
    logic                  active_q, active_d;

    assign tick = active_q && (div_q == '0);
    assign done = tick && (bit_cnt_q == 4'(FRAME_BITS - 1));
    // The shifter fills with ones, so its MSB is also the idle level.
    assign sout = shift_q[FRAME_BITS-1];

    always_comb begin
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        div_d     = div_q;
        active_d  = active_q;
        if (start) begin
            shift_d   = {1'b0, tx_type, tx_byte, 1'b1};
            bit_cnt_d = '0;
            div_d     = DIV_LOAD;
            active_d  = 1'b1;
        end else if (active_q) begin
            if (tick) begin
                shift_d   = {shift_q[FRAME_BITS-2:0], 1'b1};
                bit_cnt_d = bit_cnt_q + 4'd1;
                div_d     = DIV_LOAD;
                if (done) active_d = 1'b0;
            end else begin
                div_d = div_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q   <= '1;
            bit_cnt_q <= '0;
            div_q     <= '0;
            active_q  <= 1'b0;
        end else begin
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            div_q     <= div_d;
            active_q  <= active_d;
        end
    end

endmodule

// File: rtl/mtm_alu_serializer.sv
// mtm_alu_serializer: captures one ALU result {C, CTL} and sends it on sout.
//   Data response (CTL[7]=0): C[31:24], C[23:16], C[15:8], C[7:0], then CTL.
//   Error response (CTL[7]=1): CTL frame only.
//   clk, rst  clock, asynchronous active-high reset
//   bus       slave side of mtm_alu_serializer_if (handshake, C, CTL_in, sout, busy)
// Parameters: BIT_CYCLES clk cycles per bit; GAP_BITS idle bit times after a
// packet, honoured only when MTM_SER_GAP_EN is defined.
module mtm_alu_serializer
    import mtm_alu_pkg::*;
#(
    parameter int BIT_CYCLES = 1,
    parameter int GAP_BITS   = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    mtm_alu_serializer_if.slave        bus
);

`ifdef MTM_SER_GAP_EN
    localparam bit GAP_EN = 1'b1;
`else
    localparam bit GAP_EN = 1'b0;
`endif
    localparam int              GAP_CYCLES = GAP_BITS * BIT_CYCLES;
    localparam int              GAP_W      = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD   = GAP_W'(GAP_CYCLES - 1);

    ser_state_e       state_q, state_d;
    logic [2:0]       frames_q, frames_d;     // frames left, including the one on the line
    logic [2:0]       data_cnt_q, data_cnt_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic [31:0]      c_q, c_d;
    logic [7:0]       ctl_q, ctl_d;

    logic       transfer, next_frame, tx_start, tx_type, tx_sout, tx_tick, tx_done;
    logic [2:0] frames_new;
    logic [7:0] tx_byte;

    assign transfer   = bus.in_valid && (state_q == ST_IDLE);
    assign next_frame = (state_q == ST_STOP) && tx_done && (frames_q > 3'd1);
    assign tx_start   = transfer || next_frame;

    // On a transfer the first frame is taken straight from the bus, since the
    // capture registers only load at that same edge.
    always_comb begin
        if (transfer) begin
            frames_new = bus.CTL_in[7] ? 3'd1 : DATA_FRAMES;
            tx_byte    = frame_byte(bus.C, bus.CTL_in, frames_new);
        end else begin
            frames_new = frames_q - 3'd1;
            tx_byte    = frame_byte(c_q, ctl_q, frames_new);
        end
        tx_type = (frames_new == 3'd1) ? TYPE_CTL : TYPE_DATA;
    end

    always_comb begin
        state_d    = state_q;
        frames_d   = tx_start ? frames_new : frames_q;
        data_cnt_d = data_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        c_d        = c_q;
        ctl_d      = ctl_q;
        case (state_q)
            ST_IDLE: begin
                if (transfer) begin
                    c_d     = bus.C;
                    ctl_d   = bus.CTL_in;
                    state_d = ST_START;
                end
            end
            ST_START: if (tx_tick) state_d = ST_TYPE;
            ST_TYPE: begin
                if (tx_tick) begin
                    state_d    = ST_DATA;
                    data_cnt_d = '0;
                end
            end
            ST_DATA: begin
                if (tx_tick) begin
                    if (data_cnt_q == 3'd7) state_d = ST_STOP;
                    else                    data_cnt_d = data_cnt_q + 3'd1;
                end
            end
            ST_STOP: begin
                if (tx_done) begin
                    if (frames_q > 3'd1) begin
                        state_d = ST_START;
                    end else if (GAP_EN && (GAP_CYCLES > 0)) begin
                        state_d   = ST_GAP;
                        gap_cnt_d = GAP_LOAD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == '0) state_d = ST_IDLE;
                else                 gap_cnt_d = gap_cnt_q - 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            frames_q   <= '0;
            data_cnt_q <= '0;
            gap_cnt_q  <= '0;
            c_q        <= '0;
            ctl_q      <= '0;
        end else begin
            state_q    <= state_d;
            frames_q   <= frames_d;
            data_cnt_q <= data_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            c_q        <= c_d;
            ctl_q      <= ctl_d;
        end
    end

    mtm_alu_frame_tx #(.BIT_CYCLES(BIT_CYCLES)) u_frame_tx (
        .clk     (clk),
        .rst     (rst),
        .start   (tx_start),
        .tx_type (tx_type),
        .tx_byte (tx_byte),
        .sout    (tx_sout),
        .tick    (tx_tick),
        .done    (tx_done)
    );

    assign bus.in_ready = (state_q == ST_IDLE);
    assign bus.busy     = (state_q != ST_IDLE);
    assign bus.sout     = tx_sout;

endmodule

// File: tb/tb_mtm_alu_serializer.sv
// Scoreboard bench for mtm_alu_serializer: one DUT at BIT_CYCLES=1, one at 4.
// Stimulus pushes the expected packet bit string; a monitor per DUT captures
// each packet from sout and compares it against the queue head.
module tb_mtm_alu_serializer;

    typedef struct {
        logic [54:0] bits;
        int          nbits;
    } pkt_t;

`ifdef MTM_SER_GAP_EN
    localparam int GAP_BITS_TB = 2;
`else
    localparam int GAP_BITS_TB = 0;
`endif
    localparam int GAP1 = GAP_BITS_TB * 1;
    localparam int GAP4 = GAP_BITS_TB * 4;

    logic clk = 1'b0;
    logic rst1, rst4;
    int   checks = 0;
    int   fails  = 0;
    pkt_t q0[$];
    pkt_t q1[$];

    always #5 clk = ~clk;

    mtm_alu_serializer_if bus1();
    mtm_alu_serializer_if bus4();

    mtm_alu_serializer #(.BIT_CYCLES(1), .GAP_BITS(2)) u_dut1 (.clk(clk), .rst(rst1), .bus(bus1));
    mtm_alu_serializer #(.BIT_CYCLES(4), .GAP_BITS(2)) u_dut4 (.clk(clk), .rst(rst4), .bus(bus4));

    function automatic logic get_sout(int d);  return (d == 0) ? bus1.sout     : bus4.sout;     endfunction
    function automatic logic get_ready(int d); return (d == 0) ? bus1.in_ready : bus4.in_ready; endfunction
    function automatic logic get_busy(int d);  return (d == 0) ? bus1.busy     : bus4.busy;     endfunction
    function automatic logic get_rst(int d);   return (d == 0) ? rst1          : rst4;          endfunction

    function automatic int q_size(int d); return (d == 0) ? q0.size() : q1.size(); endfunction
    function automatic void q_push(int d, pkt_t p);
        if (d == 0) q0.push_back(p); else q1.push_back(p);
    endfunction
    function automatic pkt_t q_pop(int d);
        return (d == 0) ? q0.pop_front() : q1.pop_front();
    endfunction
    function automatic int q_peek_nbits(int d);
        if (q_size(d) == 0) return 55;
        return (d == 0) ? q0[0].nbits : q1[0].nbits;
    endfunction

    function automatic pkt_t lit(logic [54:0] b, int n);
        pkt_t p;
        p.bits  = b;
        p.nbits = n;
        return p;
    endfunction

    function automatic logic [10:0] frm(logic t, logic [7:0] b);
        return {1'b0, t, b, 1'b1};
    endfunction

    function automatic pkt_t mk_pkt(logic [31:0] c, logic [7:0] ctl);
        if (ctl[7]) return lit({44'd0, frm(1'b1, ctl)}, 11);
        return lit({frm(1'b0, c[31:24]), frm(1'b0, c[23:16]), frm(1'b0, c[15:8]),
                    frm(1'b0, c[7:0]), frm(1'b1, ctl)}, 55);
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic set_in(int d, logic v, logic [31:0] c, logic [7:0] ctl);
        if (d == 0) begin
            bus1.in_valid = v; bus1.C = c; bus1.CTL_in = ctl;
        end else begin
            bus4.in_valid = v; bus4.C = c; bus4.CTL_in = ctl;
        end
    endtask

    // Called at a negedge; returns #1 after the accepting posedge.
    task automatic do_xfer(int d, logic [31:0] c, logic [7:0] ctl, pkt_t e, output int waited);
        set_in(d, 1'b1, c, ctl);
        q_push(d, e);
        waited = 0;
        while (!get_ready(d) && waited < 3000) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 3000) begin
            checks++; fails++;
            $display("FAIL dut%0d accept_timeout actual=%0d required=<3000", d, waited);
        end
        @(posedge clk);
        #1;
    endtask

    // Start bit must follow the transfer immediately; then count busy cycles.
    task automatic check_pkt(int d, int exp_low);
        int cnt;
        cnt = 0;
        @(negedge clk);
        chk($sformatf("dut%0d launch_sout", d), 64'(get_sout(d)), 64'd0);
        chk($sformatf("dut%0d launch_ready", d), 64'(get_ready(d)), 64'd0);
        while (!get_ready(d) && cnt < 3000) begin
            cnt++;
            @(negedge clk);
        end
        chk($sformatf("dut%0d busy_cycles", d), 64'(cnt), 64'(exp_low));
        chk($sformatf("dut%0d busy_after", d), 64'(get_busy(d)), 64'd0);
    endtask

    task automatic mon(int d, int bc);
        logic [54:0] act;
        logic        s;
        bit          glitch, aborted;
        int          nb;
        pkt_t        e;
        forever begin
            @(negedge clk);
            if (!get_rst(d) && get_sout(d) == 1'b0) begin
                nb = q_peek_nbits(d);
                act = '0; glitch = 0; aborted = 0;
                for (int i = 0; i < nb * bc; i++) begin
                    if (i > 0) @(negedge clk);
                    if (get_rst(d)) begin
                        aborted = 1;
                        break;
                    end
                    s = get_sout(d);
                    if (i % bc == 0) act = {act[53:0], s};
                    else if (s !== act[0]) glitch = 1;
                end
                if (aborted) begin
                    if (q_size(d) > 0) e = q_pop(d);
                end else if (q_size(d) == 0) begin
                    checks++; fails++;
                    $display("FAIL dut%0d unexpected_packet actual=0x%0h required=none", d, act);
                end else begin
                    e = q_pop(d);
                    chk($sformatf("dut%0d packet", d), {9'd0, act}, {9'd0, e.bits});
                    chk($sformatf("dut%0d bit_hold", d), 64'(glitch), 64'd0);
                end
            end
        end
    endtask

    initial mon(0, 1);
    initial mon(1, 4);

    initial begin
        int w;
        rst1 = 1'b1;
        rst4 = 1'b1;
        set_in(0, 1'b0, 32'd0, 8'd0);
        set_in(1, 1'b0, 32'd0, 8'd0);
        #12;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("dut%0d rst_sout", d), 64'(get_sout(d)), 64'd1);
            chk($sformatf("dut%0d rst_ready", d), 64'(get_ready(d)), 64'd1);
            chk($sformatf("dut%0d rst_busy", d), 64'(get_busy(d)), 64'd0);
        end
        @(negedge clk);
        rst1 = 1'b0;
        rst4 = 1'b0;
        @(negedge clk);

        // Data packet, hand-built frames: 0x001 x3, 0x003, CTL 0x0B -> 0x217
        do_xfer(0, 32'h0000_0001, 8'h0B,
                lit({11'h001, 11'h001, 11'h001, 11'h003, 11'h217}, 55), w);
        set_in(0, 1'b0, 32'd0, 8'd0);
        check_pkt(0, 55 + GAP1);

        // Error packet: CTL 0x93 -> 0x327, C ignored
        do_xfer(0, 32'hFFFF_FFFF, 8'h93, lit({44'd0, 11'h327}, 11), w);
        set_in(0, 1'b0, 32'd0, 8'd0);
        check_pkt(0, 11 + GAP1);

        // Back-pressure: next result held valid throughout the first packet
        do_xfer(0, 32'h1234_5678, 8'h05, mk_pkt(32'h1234_5678, 8'h05), w);
        set_in(0, 1'b1, 32'hA5A5_A5A5, 8'h3A);
        check_pkt(0, 55 + GAP1);
        do_xfer(0, 32'hA5A5_A5A5, 8'h3A, mk_pkt(32'hA5A5_A5A5, 8'h3A), w);
        chk("dut0 bp_accept_wait", 64'(w), 64'd0);
        set_in(0, 1'b0, 32'd0, 8'd0);
        check_pkt(0, 55 + GAP1);

        // Reset in the middle of a packet, then a fresh packet
        do_xfer(0, 32'hDEAD_BEEF, 8'h00, mk_pkt(32'hDEAD_BEEF, 8'h00), w);
        set_in(0, 1'b0, 32'd0, 8'd0);
        repeat (20) @(negedge clk);
        #2 rst1 = 1'b1;
        #1;
        chk("dut0 midrst_sout", 64'(get_sout(0)), 64'd1);
        chk("dut0 midrst_ready", 64'(get_ready(0)), 64'd1);
        chk("dut0 midrst_busy", 64'(get_busy(0)), 64'd0);
        @(negedge clk);
        #3 rst1 = 1'b0;
        @(negedge clk);
        do_xfer(0, 32'h0000_0000, 8'h93, lit({44'd0, 11'h327}, 11), w);
        set_in(0, 1'b0, 32'd0, 8'd0);
        check_pkt(0, 11 + GAP1);

        // BIT_CYCLES=4: 0x80 -> 0x101, zeros -> 0x001, CTL 0x4C -> 0x299
        do_xfer(1, 32'h8000_0000, 8'h4C,
                lit({11'h101, 11'h001, 11'h001, 11'h001, 11'h299}, 55), w);
        set_in(1, 1'b0, 32'd0, 8'd0);
        check_pkt(1, 220 + GAP4);

        repeat (5) @(negedge clk);
        chk("dut0 pending_packets", 64'(q_size(0)), 64'd0);
        chk("dut1 pending_packets", 64'(q_size(1)), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
